vram_frame_writer: RTL
======================

// Module: vram_frame_writer
// PURPOSE
//  Upstream feeder for the VGA generator's VRAM write port (vramWriteClock/Addr/InData).
//  Accepts a valid/ready sample stream (FFT/mic magnitudes), saturates each sample to the
//  VRAM word width, and writes exactly one complete frame of DEPTH words per video frame.
//  Frames start only on a vsync edge, so the display never shows a half-written frame.
//  Short frames are zero-padded; long frames are truncated and flagged.
// PARAMETERS
//  IN_W          16    input sample width (unsigned)
//  DATA_W        10    VRAM word width; saturation limit is 2**DATA_W-1
//  ADDR_W        10    VRAM address width
//  DEPTH         1024  words per frame (<= 2**ADDR_W)
//  VS_ACTIVE_LOW 1     1: the frame starts on the vsync falling edge; 0: on the rising edge
// PORTS
//  clock       in   1       system clock (CLOCK_50 domain), also drives vramWriteClock
//  reset_n     in   1       synchronous, active-low reset
//  vsync       in   1       raw vsync from hvsync/VGA generator, asynchronous to clock
//  in_valid    in   1       sample valid
//  in_ready    out  1       sample accepted when in_valid & in_ready at posedge
//  in_data     in   IN_W    unsigned sample
//  in_last     in   1       marks final sample of an input frame
//  vram_we     out  1       VRAM write enable, registered
//  vram_addr   out  ADDR_W  VRAM write address, registered
//  vram_data   out  DATA_W  VRAM write data, registered
//  frame_done  out  1       one-cycle pulse after the last write of a frame
//  overflow    out  1       sticky: a frame exceeded DEPTH samples; cleared only by reset
//  frame_count out  8       completed frames, wraps 255->0
// BEHAVIOUR
//  Reset (reset_n=0 at posedge): state=WAIT_VS, all outputs 0, vsync sync regs cleared.
//   A mid-frame reset abandons the frame. vram_we is 0 from the first reset edge.
//  vsync passes through a 2-FF synchroniser plus an edge register. The frame-start edge
//   (per VS_ACTIVE_LOW) is detected 3 cycles after the raw edge.
//  in_ready = (state==FILL) || (state==DROP). It is decoded from the state register only,
//   with no combinational path from in_valid.
//  WAIT_VS: no writes. On the vsync edge, state becomes FILL and wr_ptr becomes 0.
//   Input samples are held off because in_ready is 0.
//  FILL: on each handshake:
//   - cycle+1: vram_we=1, vram_addr=wr_ptr, vram_data=min(in_data, 2**DATA_W-1).
//   - wr_ptr increments on each handshake.
//   Transitions on the handshake:
//   - in_last=1 and wr_ptr==DEPTH-1 -> DONE.
//   - in_last=1 and wr_ptr<DEPTH-1 -> PAD.
//   - in_last=0 and wr_ptr==DEPTH-1 -> DROP.
//   No handshake means no write, and vram_we=0 that cycle.
//  PAD: one write per cycle with data 0 at wr_ptr, for the remaining addresses up to
//   DEPTH-1. The write at DEPTH-1 moves the state to DONE.
//  DROP: samples are accepted and discarded. overflow is set to 1 on the first dropped
//   sample. A handshake with in_last=1 moves the state to DONE.
//  DONE: one cycle. frame_done=1 and frame_count+1 are registered. Next state is WAIT_VS.
//  Timing and boundaries:
//   - vsync edges outside WAIT_VS are ignored; frame rate is at most one frame per vsync.
//   - An in_last coinciding with the DEPTH-th sample completes normally with no overflow.
//   - A single-sample frame (in_last on the first sample) gives 1 data write plus
//     DEPTH-1 zero writes.
//   - Write latency is 1 cycle from the handshake. At most 1 write per cycle.
//   - vram_addr never exceeds DEPTH-1.
// TESTING
//  T1 reset: hold reset_n=0 for 5 clk with in_valid=1 -> in_ready=0, vram_we=0,
//     frame_count=0, overflow=0.
//  T2 full frame: vsync edge, then 1024 samples 0..1023 back-to-back with in_last on the
//     final one -> 1024 writes addr=data=0..1023, one frame_done, frame_count=1,
//     overflow=0.
//  T3 saturation plus short frame: samples {5, 1023, 1024, 65535} with in_last on the
//     4th -> data 5, 1023, 1023, 1023 at addr 0..3, then addr 4..1023 written with 0,
//     then frame_done.
//  T4 overflow: 1030 samples with in_last on the 1030th -> only addr 0..1023 written,
//     6 samples dropped with in_ready high, overflow=1 and stays 1 over later good frames.
//  T5 vsync gating: stream before the first vsync edge -> in_ready=0 and no writes.
//     A second vsync during FILL does not restart wr_ptr.
//  T6 reset mid-frame: reset_n=0 after 300 writes -> vram_we=0 next edge and state
//     WAIT_VS. After release, the next frame starts at addr 0 only after a vsync edge.

Source files
------------

// File: rtl/vram_frame_writer.sv
// Streams saturated samples into VRAM, one complete DEPTH-word frame per vsync.
// Short frames are zero-padded, long frames are truncated with a sticky overflow flag.
module vram_frame_writer #(
  parameter int IN_W          = 16,
  parameter int DATA_W        = 10,
  parameter int ADDR_W        = 10,
  parameter int DEPTH         = 1024,
  parameter bit VS_ACTIVE_LOW = 1'b1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              vsync,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_data,
  input  logic              in_last,
  output logic              vram_we,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [DATA_W-1:0] vram_data,
  output logic              frame_done,
  output logic              overflow,
  output logic [7:0]        frame_count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [IN_W-1:0]   SAT_MAX   = IN_W'((1 << DATA_W) - 1);

  typedef enum logic [2:0] {WAIT_VS, FILL, PAD, DROP, DONE} state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   wr_ptr_reg;
  logic                vs_meta_reg, vs_sync_reg, vs_prev_reg;
  logic                frame_start;
  logic                hs;
  logic                at_last;
  logic                wr_en;
  logic                drop_hs;
  logic [DATA_W-1:0]   wr_data;

  // vsync is asynchronous: two flops to settle it, a third to find the edge.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      vs_meta_reg <= 1'b0;
      vs_sync_reg <= 1'b0;
      vs_prev_reg <= 1'b0;
    end else begin
      vs_meta_reg <= vsync;
      vs_sync_reg <= vs_meta_reg;
      vs_prev_reg <= vs_sync_reg;
    end
  end

  assign frame_start = VS_ACTIVE_LOW ? (vs_prev_reg & ~vs_sync_reg)
                                     : (~vs_prev_reg & vs_sync_reg);
  assign hs      = in_valid & in_ready;
  assign at_last = (wr_ptr_reg == LAST_ADDR);

  always_ff @(posedge clock) begin
    if (!reset_n) state_reg <= WAIT_VS;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      WAIT_VS: if (frame_start) state_next = FILL;
      FILL: begin
        if (hs) begin
          if (in_last)      state_next = at_last ? DONE : PAD;
          else if (at_last) state_next = DROP;
        end
      end
      PAD:     if (at_last) state_next = DONE;
      DROP:    if (hs && in_last) state_next = DONE;
      DONE:    state_next = WAIT_VS;
      default: state_next = WAIT_VS;
    endcase
  end

  // in_ready depends on the state register only, never on in_valid.
  always_comb begin
    in_ready = (state_reg == FILL) || (state_reg == DROP);
    wr_en    = ((state_reg == FILL) && hs) || (state_reg == PAD);
    drop_hs  = (state_reg == DROP) && hs;
    wr_data  = '0;
    if (state_reg == FILL)
      wr_data = (in_data > SAT_MAX) ? DATA_W'(SAT_MAX) : in_data[DATA_W-1:0];
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr_reg  <= '0;
      vram_we     <= 1'b0;
      vram_addr   <= '0;
      vram_data   <= '0;
      frame_done  <= 1'b0;
      overflow    <= 1'b0;
      frame_count <= '0;
    end else begin
      vram_we    <= wr_en;
      frame_done <= (state_reg == DONE);
      if (wr_en) begin
        vram_addr <= wr_ptr_reg;
        vram_data <= wr_data;
      end
      if ((state_reg == WAIT_VS) && frame_start) wr_ptr_reg <= '0;
      else if (wr_en)                          wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
      if (state_reg == DONE) frame_count <= frame_count + 8'd1;
      if (drop_hs)           overflow    <= 1'b1;
    end
  end

endmodule
